// File: rtl/incremental_encoder_decode_module.sv
// Quadrature front end: sync, deglitch, 4x decode, direction and wrapped position.
// Emits a toggle level per valid count for edge-XOR consumers downstream.
module incremental_encoder_decode_module #(
    parameter int FILTER_LEN     = 4,
    parameter int COUNTS_PER_REV = 4000,
    parameter int POS_WIDTH      = 12
) (
    input  logic                 sys_clk,
    input  logic                 reset,
    input  logic                 encoder_a_in,
    input  logic                 encoder_b_in,
    input  logic                 encoder_z_in,
    input  logic                 error_clear_in,
    output logic                 incremental_encoder_pluse_out,
    output logic                 direction_out,
    output logic [POS_WIDTH-1:0] position_out,
    output logic                 position_valid_out,
    output logic                 index_valid_out,
    output logic                 error_out
);

    localparam logic [0:0] ST_INIT = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [4:0] INIT_LAST = 5'(FILTER_LEN + 1);
    localparam logic [3:0] FLT_LAST  = 4'(FILTER_LEN - 1);
    localparam logic [POS_WIDTH-1:0] POS_MAX = POS_WIDTH'(COUNTS_PER_REV - 1);
    localparam logic [POS_WIDTH-1:0] POS_ONE = POS_WIDTH'(1);

    // Channel bit order everywhere: {A, B, Z}
    logic [2:0]      raw;
    logic [2:0]      sync1;
    logic [2:0]      sync2;
    logic [2:0]      filt;
    logic [2:0][3:0] flt_cnt;
    logic [0:0]      state;
    logic [4:0]      init_cnt;

    logic [1:0] ab;
    logic [1:0] prev_ab;
    logic       z_prev;
    logic       fwd;
    logic       rev;
    logic       illegal;
    logic       index_hit;

    assign raw = {encoder_a_in, encoder_b_in, encoder_z_in};

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state    <= ST_INIT;
            init_cnt <= '0;
            filt     <= '0;
            flt_cnt  <= '0;
        end else if (state == ST_INIT) begin
            filt    <= sync2;
            flt_cnt <= '0;
            if (init_cnt == INIT_LAST) begin
                state <= ST_RUN;
            end else begin
                init_cnt <= init_cnt + 5'd1;
            end
        end else begin
            for (int i = 0; i < 3; i++) begin
                if (sync2[i] == filt[i]) begin
                    flt_cnt[i] <= '0;
                end else if (flt_cnt[i] == FLT_LAST) begin
                    filt[i]    <= sync2[i];
                    flt_cnt[i] <= '0;
                end else begin
                    flt_cnt[i] <= flt_cnt[i] + 4'd1;
                end
            end
        end
    end

    assign ab = filt[2:1];

    always_comb begin
        fwd = 1'b0;
        rev = 1'b0;
        case ({prev_ab, ab})
            4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: fwd = 1'b1;
            4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: rev = 1'b1;
            default: ;
        endcase
    end

    assign illegal   = (prev_ab ^ ab) == 2'b11;
    assign index_hit = filt[0] & ~z_prev & (ab == 2'b11);

    // Index overrides the count's position update but not its toggle/direction
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            prev_ab                       <= '0;
            z_prev                        <= 1'b0;
            incremental_encoder_pluse_out <= 1'b0;
            direction_out                 <= 1'b0;
            position_out                  <= '0;
            position_valid_out            <= 1'b0;
            index_valid_out               <= 1'b0;
            error_out                     <= 1'b0;
        end else if (state == ST_INIT) begin
            prev_ab            <= sync2[2:1];
            z_prev             <= sync2[0];
            position_valid_out <= 1'b0;
            index_valid_out    <= 1'b0;
        end else begin
            prev_ab            <= ab;
            z_prev             <= filt[0];
            position_valid_out <= fwd | rev | index_hit;
            index_valid_out    <= index_hit;
            if (fwd | rev) begin
                incremental_encoder_pluse_out <= ~incremental_encoder_pluse_out;
                direction_out                 <= fwd;
            end
            if (index_hit) begin
                position_out <= '0;
            end else if (fwd) begin
                position_out <= (position_out == POS_MAX) ? '0 : position_out + POS_ONE;
            end else if (rev) begin
                position_out <= (position_out == '0) ? POS_MAX : position_out - POS_ONE;
            end
            if (illegal) begin
                error_out <= 1'b1;
            end else if (error_clear_in) begin
                error_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_incremental_encoder_decode_module.sv
// Bench for the quadrature front end: directed scenarios plus a random walk,
// every cycle compared against a window/gray-index reference model.
module tb_incremental_encoder_decode_module;

    localparam int FL  = 4;
    localparam int CPR = 4000;
    localparam int PW  = 12;

    logic          sys_clk = 1'b0;
    logic          reset   = 1'b1;
    logic          a       = 1'b0;
    logic          b       = 1'b0;
    logic          z       = 1'b0;
    logic          clr     = 1'b0;
    logic          pluse;
    logic          dir;
    logic [PW-1:0] pos;
    logic          pv;
    logic          iv;
    logic          err;

    int errors = 0;
    int checks = 0;

    incremental_encoder_decode_module #(
        .FILTER_LEN(FL),
        .COUNTS_PER_REV(CPR),
        .POS_WIDTH(PW)
    ) dut (
        .sys_clk(sys_clk),
        .reset(reset),
        .encoder_a_in(a),
        .encoder_b_in(b),
        .encoder_z_in(z),
        .error_clear_in(clr),
        .incremental_encoder_pluse_out(pluse),
        .direction_out(dir),
        .position_out(pos),
        .position_valid_out(pv),
        .index_valid_out(iv),
        .error_out(err)
    );

    always #5 sys_clk = ~sys_clk;

    // Reference model state
    logic [2:0] raw_q[$];
    logic [2:0] sync_q[$];
    int         n_edge;
    logic [2:0] m_f;
    logic [1:0] m_prev;
    logic       m_zprev;
    logic       m_pl, m_dir, m_pv, m_iv, m_err;
    int         m_pos;

    // Event counters observed on DUT outputs
    int   tog;
    int   pvcnt;
    int   ivcnt;
    logic last_pl = 1'b0;

    logic [1:0] fseq [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
    logic [1:0] cur_ab = 2'b00;

    function automatic int gidx(input logic [1:0] v);
        case (v)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic void model_step();
        logic [2:0] s;
        logic [1:0] cur;
        logic       rise;
        int         d;
        bit         all_diff;
        if (reset) begin
            raw_q.delete();
            sync_q.delete();
            n_edge = 0;
            m_f = '0; m_prev = '0; m_zprev = 1'b0;
            m_pl = 0; m_dir = 0; m_pv = 0; m_iv = 0; m_err = 0;
            m_pos = 0;
            return;
        end
        // value seen now = raw sampled two edges ago
        s = (raw_q.size() >= 2) ? raw_q[1] : 3'b000;
        raw_q.push_front({a, b, z});
        if (raw_q.size() > 2) void'(raw_q.pop_back());
        sync_q.push_front(s);
        if (sync_q.size() > FL) void'(sync_q.pop_back());
        m_pv = 0;
        m_iv = 0;
        if (n_edge < FL + 2) begin
            m_f = s;
            m_prev = s[2:1];
            m_zprev = s[0];
            n_edge++;
            return;
        end
        cur  = m_f[2:1];
        d    = (gidx(cur) - gidx(m_prev) + 4) % 4;
        rise = m_f[0] && !m_zprev && (cur == 2'b11);
        if (d == 1) begin
            m_pos = (m_pos + 1) % CPR;
            m_dir = 1; m_pl = ~m_pl; m_pv = 1;
        end else if (d == 3) begin
            m_pos = (m_pos + CPR - 1) % CPR;
            m_dir = 0; m_pl = ~m_pl; m_pv = 1;
        end
        if (d == 2) m_err = 1;
        else if (clr) m_err = 0;
        if (rise) begin
            m_pos = 0; m_iv = 1; m_pv = 1;
        end
        m_prev  = cur;
        m_zprev = m_f[0];
        // a channel flips once its last FL seen samples all disagree with it
        for (int c = 0; c < 3; c++) begin
            all_diff = (sync_q.size() == FL);
            foreach (sync_q[i]) if (sync_q[i][c] == m_f[c]) all_diff = 0;
            if (all_diff) m_f[c] = ~m_f[c];
        end
    endfunction

    task automatic tick();
        @(posedge sys_clk);
        model_step();
        #1;
        checks++;
        if (pluse !== m_pl || dir !== m_dir || pos !== PW'(m_pos) ||
            pv !== m_pv || iv !== m_iv || err !== m_err) begin
            errors++;
            $display("FAIL model t=%0t dut pl=%b dir=%b pos=%0d pv=%b iv=%b err=%b want pl=%b dir=%b pos=%0d pv=%b iv=%b err=%b",
                     $time, pluse, dir, pos, pv, iv, err,
                     m_pl, m_dir, m_pos, m_pv, m_iv, m_err);
        end
        if (pluse !== last_pl) tog++;
        last_pl = pluse;
        if (pv === 1'b1) pvcnt++;
        if (iv === 1'b1) ivcnt++;
    endtask

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    task automatic drive_ab(input logic [1:0] v);
        cur_ab = v;
        a = v[1];
        b = v[0];
    endtask

    task automatic do_reset(input logic [1:0] v);
        reset = 1'b1;
        drive_ab(v);
        z = 1'b0;
        clr = 1'b0;
        #1;
        chk("async_reset", int'({pluse, dir, pos, pv, iv, err}), 0);
        repeat (2) tick();
        reset = 1'b0;
        repeat (15) tick();
    endtask

    task automatic step(input bit fw, input int n, output int lat);
        logic [1:0] nx;
        nx = fw ? fseq[(gidx(cur_ab) + 1) % 4] : fseq[(gidx(cur_ab) + 3) % 4];
        drive_ab(nx);
        lat = -1;
        for (int i = 1; i <= n; i++) begin
            tick();
            if (pv === 1'b1 && lat < 0) lat = i;
        end
    endtask

    initial begin
        int lat;
        int p0;
        int r;
        int hold;

        // Reset release with A=B=1 held
        reset = 1'b1;
        drive_ab(2'b11);
        repeat (3) tick();
        reset = 1'b0;
        tog = 0;
        repeat (20) tick();
        chk("init11_toggles", tog, 0);
        chk("init11_err", int'(err), 0);
        chk("init11_pos", int'(pos), 0);
        chk("init11_dir", int'(dir), 0);

        // Eight forward steps from 00, 7-cycle latency each
        do_reset(2'b00);
        tog = 0;
        for (int k = 0; k < 8; k++) begin
            step(1'b1, 20, lat);
            chk("fwd_latency", lat, 7);
        end
        chk("fwd8_pos", int'(pos), 8);
        chk("fwd8_toggles", tog, 8);
        chk("fwd8_dir", int'(dir), 1);

        // Reverse wrap and return
        do_reset(2'b00);
        step(1'b0, 20, lat);
        chk("rev_wrap_pos", int'(pos), 3999);
        chk("rev_wrap_dir", int'(dir), 0);
        step(1'b1, 20, lat);
        chk("fwd_back_pos", int'(pos), 0);
        chk("fwd_back_dir", int'(dir), 1);

        // Glitch rejection and minimum-width acceptance on A
        p0 = int'(pos);
        tog = 0;
        a = 1'b1;
        repeat (3) tick();
        a = 1'b0;
        repeat (20) tick();
        chk("glitch3_toggles", tog, 0);
        chk("glitch3_pos", int'(pos), p0);
        pvcnt = 0;
        a = 1'b1;
        repeat (4) tick();
        a = 1'b0;
        repeat (20) tick();
        chk("pulse4_counts", pvcnt, 2);
        chk("pulse4_toggles", tog, 2);
        chk("pulse4_pos", int'(pos), p0);

        // Illegal double change, clear, and set-beats-clear
        tog = 0;
        drive_ab(2'b11);
        repeat (20) tick();
        chk("illegal_err", int'(err), 1);
        chk("illegal_pos", int'(pos), p0);
        chk("illegal_toggles", tog, 0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        chk("err_cleared", int'(err), 0);
        drive_ab(2'b00);
        repeat (6) tick();
        chk("err_before_set", int'(err), 0);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk("err_set_wins", int'(err), 1);
        repeat (3) tick();

        // Index handling
        do_reset(2'b00);
        for (int k = 0; k < 1234; k++) step(1'b1, 6, lat);
        repeat (6) tick();
        chk("pre_index_pos", int'(pos), 1234);
        ivcnt = 0;
        pvcnt = 0;
        z = 1'b1;
        repeat (15) tick();
        chk("index_pos", int'(pos), 0);
        chk("index_iv", ivcnt, 1);
        chk("index_pv", pvcnt, 1);
        z = 1'b0;
        repeat (10) tick();
        step(1'b0, 20, lat);
        chk("ab10_pos", int'(pos), 3999);
        ivcnt = 0;
        z = 1'b1;
        repeat (15) tick();
        chk("z_at_10_iv", ivcnt, 0);
        chk("z_at_10_pos", int'(pos), 3999);
        z = 1'b0;
        repeat (10) tick();
        for (int k = 0; k < 4; k++) step(1'b0, 20, lat);
        chk("pre_coincide_pos", int'(pos), 3995);
        tog = 0;
        ivcnt = 0;
        z = 1'b1;
        step(1'b1, 20, lat);
        chk("coincide_pos", int'(pos), 0);
        chk("coincide_toggles", tog, 1);
        chk("coincide_iv", ivcnt, 1);
        chk("coincide_dir", int'(dir), 1);
        z = 1'b0;
        repeat (10) tick();

        // Random walk with glitches, illegal jumps, index, clears and resets
        for (int it = 0; it < 2500; it++) begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                reset = 1'b1;
                repeat (2) tick();
                reset = 1'b0;
            end
            if (r < 10) drive_ab(2'($urandom_range(0, 3)));
            else if (r < 55) drive_ab(fseq[(gidx(cur_ab) + 1) % 4]);
            else drive_ab(fseq[(gidx(cur_ab) + 3) % 4]);
            if ($urandom_range(0, 3) == 0) z = ~z;
            clr = ($urandom_range(0, 7) == 0);
            hold = $urandom_range(1, 10);
            tick();
            clr = 1'b0;
            repeat (hold - 1) tick();
        end
        repeat (20) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
